// File: rtl/uart_pkg.sv
// Shared encodings for the framed UART transmitter: FSM states, parity/stop selects,
// and the stop-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // parity_sel: 00 none, 01 even, 10 odd, 11 none
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // stop_sel: 00 one, 01 one and a half, 10 two, 11 one
  localparam logic [1:0] STOP_1P5 = 2'b01;
  localparam logic [1:0] STOP_2   = 2'b10;

  function automatic logic parity_on(input logic [1:0] sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

  function automatic logic parity_odd(input logic [1:0] sel);
    return sel == PAR_ODD;
  endfunction

  // Number of s_tick pulses the stop level is held for.
  function automatic int unsigned stop_ticks(input logic [1:0] sel, input int unsigned os_tick);
    case (sel)
      STOP_1P5: return (3 * os_tick) / 2;
      STOP_2:   return 2 * os_tick;
      default:  return os_tick;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, DBIT data bits LSB first, optional parity, 1/1.5/2 stop bits.
// Define UART_TX_PARITY_EN to build the parity stage; otherwise parity_sel is ignored.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned OS_TICK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_din,
  input  logic [1:0]      parity_sel,
  input  logic [1:0]      stop_sel,
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int unsigned TW = $clog2(2 * OS_TICK);
  localparam int unsigned BW = $clog2(DBIT);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OS_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DBIT - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] sreg_q, sreg_d;
  logic [1:0]      stop_q, stop_d;
  logic            tx_q, tx_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [TW-1:0]   stop_last_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_q, par_d;
`else
  logic unused_parity_sel;
  assign unused_parity_sel = ^parity_sel;
`endif

  assign stop_last_c = TW'(stop_ticks(stop_q, OS_TICK) - 1);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_d    = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // A tick coincident with acceptance is deliberately not counted.
        if (tx_start) begin
          state_d = ST_START;
          tick_d  = '0;
          bit_d   = '0;
          sreg_d  = tx_din;
          stop_d  = stop_sel;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_en_d = parity_on(parity_sel);
          par_d    = (^tx_din) ^ parity_odd(parity_sel);
`endif
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = ST_DATA;
            tx_d    = sreg_q[0];
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d = '0;
            if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_d = ST_PARITY;
                tx_d    = par_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
`else
              state_d = ST_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_d  = bit_q + BW'(1);
              sreg_d = sreg_q >> 1;
              tx_d   = sreg_q[1];
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        tx_d = 1'b1;
        if (s_tick) begin
          if (tick_q == stop_last_c) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      par_en_q <= par_en_d;
      par_q    <= par_d;
    end
  end
`endif

  assign tx           = tx_q;
  assign tx_ready     = ready_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: per-tick waveform model checked every cycle, plus directed frames.
module tb_uart_tx_framed;

  logic       clk;
  logic       reset_n;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] tx_din;
  logic [1:0] parity_sel;
  logic [1:0] stop_sel;
  logic       tx_ready;
  logic       tx_done_tick;
  logic       tx;

  int errors = 0;
  int checks = 0;

  uart_tx_framed #(.DBIT(8), .OS_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .parity_sel   (parity_sel),
    .stop_sel     (stop_sel),
    .tx_ready     (tx_ready),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as the line level during each successive s_tick of the frame.
  function automatic void build(input logic [7:0] d, input logic [1:0] ps, input logic [1:0] ss,
                                output logic w[$]);
    logic pe;
    int   stop_n;
    w = {};
    for (int k = 0; k < 16; k++) w.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 16; k++) w.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    pe = (ps == 2'b01) || (ps == 2'b10);
`else
    pe = 1'b0;
`endif
    if (pe)
      for (int k = 0; k < 16; k++) w.push_back((^d) ^ (ps == 2'b10));
    stop_n = (ss == 2'b01) ? 24 : (ss == 2'b10) ? 32 : 16;
    for (int k = 0; k < stop_n; k++) w.push_back(1'b1);
  endfunction

  // Reference model plus per-cycle compare.
  logic m_active = 1'b0;
  int   m_pos = 0;
  logic m_wave[$];
  logic e_done;

  initial begin
    forever begin
      @(posedge clk);
      e_done = 1'b0;
      if (!reset_n) begin
        m_active = 1'b0;
      end else if (m_active) begin
        if (s_tick) begin
          m_pos++;
          if (m_pos == m_wave.size()) begin
            m_active = 1'b0;
            e_done   = 1'b1;
          end
        end
      end else if (tx_start) begin
        build(tx_din, parity_sel, stop_sel, m_wave);
        m_active = 1'b1;
        m_pos    = 0;
      end
      #1;
      chk("model_tx", 32'(tx), m_active ? 32'(m_wave[m_pos]) : 32'd1);
      chk("model_ready", 32'(tx_ready), 32'(!m_active));
      chk("model_done", 32'(tx_done_tick), 32'(e_done));
    end
  end

  // Drive one frame; records the line level mid-bit. mode 1: 0xFF pulse mid-data, mode 2: hold tx_start.
  task automatic send_frame(input logic [7:0] din, input logic [1:0] ps, input logic [1:0] ss,
                            input int mode, input int rst_tick,
                            output int ticks, output logic [15:0] bits);
    logic t;
    logic got_done;
    ticks    = 0;
    bits     = '1;
    got_done = 1'b0;
    @(negedge clk);
    tx_din = din; parity_sel = ps; stop_sel = ss; tx_start = 1'b1; s_tick = 1'b1;
    @(posedge clk); #1;
    chk("start_bit_latency", 32'(tx), 32'd0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (mode != 2) tx_start = 1'b0;
      if (mode == 1 && ticks == 40) begin
        tx_start = 1'b1; tx_din = 8'hFF; parity_sel = ~ps; stop_sel = 2'b10;
      end
      if (rst_tick != 0 && ticks == rst_tick) begin
        reset_n = 1'b0; s_tick = 1'b0; tx_start = 1'b0;
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_done", 32'(tx_done_tick), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      s_tick = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      t = s_tick;
      #1;
      if (t) begin
        ticks++;
        if (ticks % 16 == 8) bits[ticks / 16] = tx;
      end
      if (tx_done_tick) begin
        got_done = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", 32'(got_done), 32'd1);
  endtask

  task automatic drain();
    logic idle = 1'b0;
    for (int cyc = 0; cyc < 3000 && !idle; cyc++) begin
      @(negedge clk);
      s_tick = 1'b1; tx_start = 1'b0;
      @(posedge clk); #1;
      idle = tx_ready;
    end
    chk("drain_idle", 32'(idle), 32'd1);
  endtask

  task automatic idle_check(input string name);
    int bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s_tick = 1'b1; tx_start = 1'b0;
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_done_tick !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  int          ticks;
  logic [15:0] bits;
  logic [9:0]  e_a5 = 10'b1101001010;
  logic [9:0]  e_3c = 10'b1001111000;
  logic        pin_wave[$];

  initial begin
    reset_n = 1'b0; s_tick = 1'b0; tx_start = 1'b0;
    tx_din = '0; parity_sel = '0; stop_sel = '0;

    // Pin the model against the hand-derived 0xA5 frame.
    build(8'hA5, 2'b00, 2'b00, pin_wave);
    chk("model_len_8n1", 32'(pin_wave.size()), 32'd160);
    for (int i = 0; i < 10; i++) chk("model_a5_bit", 32'(pin_wave[16 * i + 8]), 32'(e_a5[i]));

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(tx_done_tick), 32'd0);
    reset_n = 1'b1;

    send_frame(8'hA5, 2'b00, 2'b00, 0, 0, ticks, bits);
    for (int i = 0; i < 10; i++) chk("a5_bit", 32'(bits[i]), 32'(e_a5[i]));
    chk("a5_ticks", 32'(ticks), 32'd160);
    idle_check("a5_single_done");

    send_frame(8'h96, 2'b00, 2'b01, 0, 0, ticks, bits);
    chk("stop_1p5_high_ticks", 32'(ticks - 144), 32'd24);
    send_frame(8'h96, 2'b00, 2'b10, 0, 0, ticks, bits);
    chk("stop_2_high_ticks", 32'(ticks - 144), 32'd32);
    send_frame(8'h96, 2'b00, 2'b11, 0, 0, ticks, bits);
    chk("stop_11_ticks", 32'(ticks), 32'd160);

`ifdef UART_TX_PARITY_EN
    send_frame(8'h07, 2'b01, 2'b00, 0, 0, ticks, bits);
    chk("even_parity_bit", 32'(bits[9]), 32'd1);
    chk("parity_frame_ticks", 32'(ticks), 32'd176);
    send_frame(8'h07, 2'b10, 2'b00, 0, 0, ticks, bits);
    chk("odd_parity_bit", 32'(bits[9]), 32'd0);
    chk("odd_frame_ticks", 32'(ticks), 32'd176);
`else
    send_frame(8'h07, 2'b01, 2'b00, 0, 0, ticks, bits);
    chk("parity_ignored_ticks", 32'(ticks), 32'd160);
    chk("parity_ignored_stop", 32'(bits[9]), 32'd1);
`endif

    send_frame(8'h00, 2'b00, 2'b00, 1, 0, ticks, bits);
    for (int i = 1; i < 9; i++) chk("midframe_data_bit", 32'(bits[i]), 32'd0);
    chk("midframe_ticks", 32'(ticks), 32'd160);
    idle_check("midframe_no_second_frame");

    send_frame(8'h33, 2'b00, 2'b00, 2, 0, ticks, bits);
    @(posedge clk); #1;
    chk("b2b_start_tx", 32'(tx), 32'd0);
    chk("b2b_start_ready", 32'(tx_ready), 32'd0);
    drain();

    send_frame(8'h55, 2'b00, 2'b00, 0, 16 * 4 + 5, ticks, bits);
    idle_check("post_reset_idle");
    send_frame(8'h3C, 2'b00, 2'b00, 0, 0, ticks, bits);
    for (int i = 0; i < 10; i++) chk("post_reset_3c_bit", 32'(bits[i]), 32'(e_3c[i]));
    chk("post_reset_3c_ticks", 32'(ticks), 32'd160);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      s_tick     = ($urandom_range(0, 2) == 0);
      tx_start   = ($urandom_range(0, 7) == 0);
      tx_din     = 8'($urandom);
      parity_sel = 2'($urandom);
      stop_sel   = 2'($urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
